// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one single-port 8-bit frame-buffer RAM between the
// HDMI scan-out reader and a FIFO-buffered host pixel writer (video_clk domain).
// Scan-out always wins the port; buffered host writes retire in idle cycles.
//
// Optional feature macro: FB_PINGPONG_EN (two banks, vs-synchronised swap).
//
// Ports:
//   video_clk, rst          clock, asynchronous active-high reset
//   vs                      frame sync level; rising edge marks a frame boundary
//   disp_rd_req/addr        scan-out read request and pixel address
//   disp_rd_data/vld        read pixel, valid one cycle after the read grant
//   host_wr_valid/ready     host write handshake
//   host_wr_addr/data       host pixel address and value
//   swap_req, swap_done     buffer swap request pulse / swap performed pulse
//   bank_sel                current front (display) bank
//   fifo_level              host write FIFO occupancy
//   drop_cnt                saturating count of out-of-range host writes
//   ram_en/we/addr/wdata    RAM control, combinational from the grant decision
//   ram_rdata               RAM read data, 1-cycle latency
module fb_port_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DEPTH      = 784,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          video_clk,
  input  logic                          rst,
  input  logic                          vs,
  input  logic                          disp_rd_req,
  input  logic [ADDR_W-1:0]             disp_rd_addr,
  output logic [7:0]                    disp_rd_data,
  output logic                          disp_rd_vld,
  input  logic                          host_wr_valid,
  output logic                          host_wr_ready,
  input  logic [ADDR_W-1:0]             host_wr_addr,
  input  logic [7:0]                    host_wr_data,
  input  logic                          swap_req,
  output logic                          swap_done,
  output logic                          bank_sel,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_cnt,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [ADDR_W:0]               ram_addr,
  output logic [7:0]                    ram_wdata,
  input  logic [7:0]                    ram_rdata
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {GNT_IDLE, GNT_RD, GNT_WR} gnt_t;

  gnt_t              gnt_d;
  gnt_t              gnt_q;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [7:0]        fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              fifo_empty;
  logic              fifo_full;
  logic              accept;
  logic              in_range;
  logic              push;
  logic              pop;
  logic [7:0]        rd_hold;
  logic              bank_q;
  logic              wr_bank;
  logic              swap_done_q;

  assign fifo_empty    = (fifo_level == '0);
  assign fifo_full     = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign host_wr_ready = !rst && !fifo_full;
  assign accept        = host_wr_valid && host_wr_ready;
  assign in_range      = (32'(host_wr_addr) < DEPTH);
  assign push          = accept && in_range;
  assign pop           = (gnt_d == GNT_WR);

  // Grant: scan-out first, then FIFO head; nothing is granted while in reset
  always_comb begin
    gnt_d = GNT_IDLE;
    if (rst)                gnt_d = GNT_IDLE;
    else if (disp_rd_req)   gnt_d = GNT_RD;
    else if (!fifo_empty)   gnt_d = GNT_WR;
  end

  // RAM port drive from the grant decision
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (gnt_d)
      GNT_RD: begin
        ram_en   = 1'b1;
        ram_addr = {bank_q, disp_rd_addr};
      end
      GNT_WR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = {wr_bank, fifo_addr[rd_ptr]};
        ram_wdata = fifo_data[rd_ptr];
      end
      default: ;
    endcase
  end

  // Grant state, FIFO pointers/level, drop counter, read-data hold
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      gnt_q      <= GNT_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drop_cnt   <= '0;
      rd_hold    <= '0;
    end else begin
      gnt_q <= gnt_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;
      if (accept && !in_range && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 1'b1;
      if (disp_rd_vld) rd_hold <= ram_rdata;
    end
  end

  // FIFO storage needs no reset: occupancy is tracked by the pointers
  always_ff @(posedge video_clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= host_wr_addr;
      fifo_data[wr_ptr] <= host_wr_data;
    end
  end

  // Read data is presented the cycle after the grant and held between reads
  assign disp_rd_vld  = (gnt_q == GNT_RD);
  assign disp_rd_data = disp_rd_vld ? ram_rdata : rd_hold;

`ifdef FB_PINGPONG_EN
  logic vs_q;
  logic swap_pending;
  logic swap_go;

  // Swap only at a frame boundary and only once all back-bank writes retired
  assign swap_go = vs && !vs_q && (swap_pending || swap_req) && fifo_empty;
  assign wr_bank = ~bank_q;

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      vs_q         <= 1'b0;
      swap_pending <= 1'b0;
      bank_q       <= 1'b0;
      swap_done_q  <= 1'b0;
    end else begin
      vs_q        <= vs;
      swap_done_q <= swap_go;
      if (swap_go) begin
        bank_q       <= ~bank_q;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end
`else
  logic unused_swap;

  // Single bank: display and host writes share bank 0
  assign unused_swap = ^{vs, swap_req};
  assign bank_q      = 1'b0;
  assign wr_bank     = 1'b0;
  assign swap_done_q = 1'b0;
`endif

  assign bank_sel  = bank_q;
  assign swap_done = swap_done_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Testbench for fb_port_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_fb_port_arbiter;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 784;
  localparam int unsigned FD     = 4;
`ifdef FB_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic              video_clk = 1'b0;
  logic              rst;
  logic              vs;
  logic              disp_rd_req;
  logic [ADDR_W-1:0] disp_rd_addr;
  logic [7:0]        disp_rd_data;
  logic              disp_rd_vld;
  logic              host_wr_valid;
  logic              host_wr_ready;
  logic [ADDR_W-1:0] host_wr_addr;
  logic [7:0]        host_wr_data;
  logic              swap_req;
  logic              swap_done;
  logic              bank_sel;
  logic [2:0]        fifo_level;
  logic [7:0]        drop_cnt;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W:0]   ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  always #5 video_clk = ~video_clk;

  fb_port_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
    .video_clk(video_clk), .rst(rst), .vs(vs),
    .disp_rd_req(disp_rd_req), .disp_rd_addr(disp_rd_addr),
    .disp_rd_data(disp_rd_data), .disp_rd_vld(disp_rd_vld),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .swap_req(swap_req), .swap_done(swap_done), .bank_sel(bank_sel),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [7:0] init_val(input int a);
    return 8'(a * 37 + 11);
  endfunction

  // Environment RAM: single port, registered read
  logic [7:0] ram_mem [2048];
  bit         ram_wr  [2048];
  always @(posedge video_clk) begin
    if (ram_en) begin
      if (ram_we) begin
        ram_mem[ram_addr] <= ram_wdata;
        ram_wr[ram_addr]  <= 1'b1;
      end else begin
        ram_rdata <= ram_wr[ram_addr] ? ram_mem[ram_addr] : init_val(int'(ram_addr));
      end
    end
  end

  // Reference model state
  typedef struct packed { logic [9:0] addr; logic [7:0] data; } wr_t;
  wr_t        q[$];
  logic [7:0] ref_mem [2048];
  int         m_drop;
  bit         m_bank, m_pend, m_vsp, m_done, m_vld;
  logic [7:0] m_data;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_drop = 0; m_bank = 0; m_pend = 0; m_vsp = 0; m_done = 0; m_vld = 0; m_data = 8'h00;
  endtask

  // Compare every DUT output with what the model expects this cycle
  task automatic model_check();
    int n = q.size();
    int wb = PP ? (1 - int'(m_bank)) : 0;
    chk("ready", host_wr_ready, n < FD);
    chk("ram_en", ram_en, disp_rd_req || n > 0);
    chk("ram_we", ram_we, !disp_rd_req && n > 0);
    if (disp_rd_req) chk("ram_addr_rd", ram_addr, int'(m_bank) * 1024 + int'(disp_rd_addr));
    else if (n > 0) begin
      chk("ram_addr_wr", ram_addr, wb * 1024 + int'(q[0].addr));
      chk("ram_wdata", ram_wdata, q[0].data);
    end
    chk("fifo_level", fifo_level, n);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("bank_sel", bank_sel, m_bank);
    chk("swap_done", swap_done, m_done);
    chk("rd_vld", disp_rd_vld, m_vld);
    chk("rd_data", disp_rd_data, m_data);
  endtask

  // Advance the model across one clock edge using the current inputs
  task automatic model_step();
    int n = q.size();
    int wb = PP ? (1 - int'(m_bank)) : 0;
    wr_t h;
    if (disp_rd_req) begin
      m_vld  = 1;
      m_data = ref_mem[int'(m_bank) * 1024 + int'(disp_rd_addr)];
    end else begin
      m_vld = 0;
      if (n > 0) begin
        h = q.pop_front();
        ref_mem[wb * 1024 + int'(h.addr)] = h.data;
      end
    end
    if (host_wr_valid && n < FD) begin
      if (int'(host_wr_addr) >= DEPTH) begin
        if (m_drop < 255) m_drop++;
      end else begin
        q.push_back({host_wr_addr, host_wr_data});
      end
    end
    m_done = 0;
    if (PP) begin
      if (swap_req) m_pend = 1;
      if (vs && !m_vsp && m_pend && n == 0) begin
        m_bank = !m_bank;
        m_pend = 0;
        m_done = 1;
      end
    end
    m_vsp = vs;
  endtask

  task automatic cyc(input bit rq, input int ra, input bit wv, input int wa,
                     input int wd, input bit sr, input bit v);
    @(posedge video_clk);
    #1;
    disp_rd_req   = rq;
    disp_rd_addr  = ADDR_W'(ra);
    host_wr_valid = wv;
    host_wr_addr  = ADDR_W'(wa);
    host_wr_data  = 8'(wd);
    swap_req      = sr;
    vs            = v;
    #1;
    model_check();
    model_step();
  endtask

  task automatic idle_inputs();
    disp_rd_req = 0; disp_rd_addr = '0; host_wr_valid = 0; host_wr_addr = '0;
    host_wr_data = '0; swap_req = 0; vs = 0;
  endtask

  typedef struct {
    bit rq; int ra; bit wv; int wa; int wd;
    int e_ready; int e_en; int e_we; int e_addr; int e_level; int e_drop; int e_vld;
  } vec_t;

  vec_t tbl[6];
  int   wbase;
  int   cnt;
  int   done_cnt;

  initial begin
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(i);
    wbase = PP ? 1024 : 0;
    //        rq ra wv  wa    wd     rdy en we addr       lvl drp vld
    tbl[0] = '{0, 0, 1, 5,    'hA3,  1,  0, 0, 0,         0,  0,  0};
    tbl[1] = '{0, 0, 0, 0,    0,     1,  1, 1, wbase + 5, 1,  0,  0};
    tbl[2] = '{0, 0, 1, 784,  'h11,  1,  0, 0, 0,         0,  0,  0};
    tbl[3] = '{0, 0, 1, 1023, 'h22,  1,  0, 0, 0,         0,  1,  0};
    tbl[4] = '{1, 5, 0, 0,    0,     1,  1, 0, 5,         0,  2,  0};
    tbl[5] = '{0, 0, 0, 0,    0,     1,  0, 0, 0,         0,  2,  1};

    // Reset with active requests: everything must stay quiet
    rst = 1;
    idle_inputs();
    disp_rd_req = 1; host_wr_valid = 1;
    repeat (3) @(posedge video_clk);
    #2;
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ready", host_wr_ready, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_vld", disp_rd_vld, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_bank", bank_sel, 0);
    idle_inputs();
    @(posedge video_clk);
    #1 rst = 0;
    model_reset();

    // Directed vector table: write, out-of-range drops, read of a bank-0 address
    for (int r = 0; r < 6; r++) begin
      cyc(tbl[r].rq, tbl[r].ra, tbl[r].wv, tbl[r].wa, tbl[r].wd, 1'b0, 1'b0);
      chk("vec_ready", host_wr_ready, tbl[r].e_ready);
      chk("vec_en", ram_en, tbl[r].e_en);
      chk("vec_we", ram_we, tbl[r].e_we);
      if (tbl[r].e_en != 0) chk("vec_addr", ram_addr, tbl[r].e_addr);
      chk("vec_level", fifo_level, tbl[r].e_level);
      chk("vec_drop", drop_cnt, tbl[r].e_drop);
      chk("vec_vld", disp_rd_vld, tbl[r].e_vld);
    end

    // Read priority: 6 host writes offered during 20 continuous reads
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1, i, i < 6, 100 + i, 'h40 + i, 0, 0);
      if (ram_we) cnt++;
      if (i < 6) chk("prio_ready", host_wr_ready, i < 4);
    end
    chk("prio_no_wr", cnt, 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      if (i == 0) chk("prio_level", fifo_level, 4);
      if (ram_we) cnt++;
    end
    chk("prio_retire", cnt, 4);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("prio_empty", fifo_level, 0);

    // Drop counter saturation
    for (int i = 0; i < 300; i++) cyc(0, 0, 1, 784 + (i % 240), i, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("drop_sat", drop_cnt, 255);

    // Swap deferred while the FIFO is non-empty, then taken at the next vs edge
    done_cnt = 0;
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(1, 1, 1, 10, 1, 0, 0);   done_cnt += int'(swap_done);
    cyc(1, 2, 1, 11, 2, 0, 0);   done_cnt += int'(swap_done);
    cyc(1, 3, 0, 0, 0, 0, 1);    done_cnt += int'(swap_done);
    cyc(1, 4, 0, 0, 0, 0, 1);    done_cnt += int'(swap_done);
    chk("defer_bank", bank_sel, 0);
    chk("defer_level", fifo_level, 2);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      done_cnt += int'(swap_done);
    end
    chk("drain_level", fifo_level, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);    done_cnt += int'(swap_done);
    cyc(0, 0, 0, 0, 0, 0, 1);    done_cnt += int'(swap_done);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("swap_bank", bank_sel, PP);
    chk("swap_pulse", swap_done, PP);
    done_cnt += int'(swap_done);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      done_cnt += int'(swap_done);
    end
    chk("swap_once", done_cnt, PP);
    cyc(1, 5, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("readback_vld", disp_rd_vld, 1);
    chk("readback_data", disp_rd_data, 8'hA3);

    // Reset mid-burst with three queued writes and a read outstanding
    for (int i = 0; i < 3; i++) cyc(1, i, 1, 200 + i, 'h50 + i, 0, 0);
    cyc(1, 7, 0, 0, 0, 0, 0);
    chk("burst_level", fifo_level, 3);
    #1 rst = 1;
    #1;
    chk("mid_rst_vld", disp_rd_vld, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_en", ram_en, 0);
    idle_inputs();
    cnt = 0;
    repeat (3) begin
      @(posedge video_clk);
      #2;
      if (ram_we || disp_rd_vld) cnt++;
    end
    @(posedge video_clk);
    #1 rst = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      if (ram_we || disp_rd_vld) cnt++;
    end
    chk("post_rst_quiet", cnt, 0);
    chk("post_rst_bank", bank_sel, 0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      automatic bit rq = ($urandom_range(0, 99) < 55);
      automatic bit wv = ($urandom_range(0, 99) < 50);
      automatic int wa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(784, 1023))
                                                     : int'($urandom_range(0, 783));
      cyc(rq, int'($urandom_range(0, 783)), wv, wa, int'($urandom_range(0, 255)),
          $urandom_range(0, 99) < 3, (i % 60) < 30);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares one single-port 8-bit frame-buffer RAM between two requesters: the HDMI scan-out read port and the host (CPU-side) pixel write port.
- Scan-out has absolute priority. Host writes are buffered in a small FIFO and retired in idle cycles.
- Sits between the pixel RAM and img2hdmi in the video_clk domain. Host requests arrive already synchronised to video_clk.

Parameters:
- ADDR_W, 10, pixel address width
- DEPTH, 784, valid pixel addresses 0..DEPTH-1
- FIFO_DEPTH, 4, host write FIFO entries (power of 2, ≥2)

Ports:
- video_clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- vs  in  1  frame sync from img2hdmi (level; rising edge = frame boundary)
- disp_rd_req  in  1  scan-out read request
- disp_rd_addr  in  ADDR_W  scan-out pixel address
- disp_rd_data  out  8  read pixel (valid when disp_rd_vld)
- disp_rd_vld  out  1  read data valid
- host_wr_valid  in  1  host write request
- host_wr_ready  out  1  host write accepted when valid&ready
- host_wr_addr  in  ADDR_W  host pixel address
- host_wr_data  in  8  host pixel value
- swap_req  in  1  one-cycle pulse: request buffer swap
- swap_done  out  1  one-cycle pulse: swap performed
- bank_sel  out  1  current front (display) bank
- fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- drop_cnt  out  8  saturating count of discarded out-of-range host writes
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W+1  {bank, pixel address}
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data, registered, 1-cycle latency

Behaviour:
- Reset values: all outputs 0, FIFO empty, host_wr_ready 0 during reset and 1 from the first cycle after release, swap_pending 0.
- Per-cycle grant, registered FSM state GNT ∈ {IDLE, RD, WR}:
  - disp_rd_req=1 → RD: ram_en=1, ram_we=0, ram_addr={bank_sel, disp_rd_addr}.
  - Else FIFO non-empty → WR: pop head; ram_en=1, ram_we=1, ram_addr={~bank_sel, head.addr}, ram_wdata=head.data.
  - Else IDLE: ram_en=0.
  - ram_* outputs are combinational from the grant decision.
- Read latency: disp_rd_vld is asserted exactly 1 cycle after an RD grant. disp_rd_data=ram_rdata in that cycle. Back-to-back reads give one result per cycle. disp_rd_data holds its value when vld=0.
- host_wr_ready = !full.
- Host address check on acceptance: if addr ≥ DEPTH, the write is accepted and discarded (not pushed), and drop_cnt increments, saturating at 255.
- A pushed write is retired no earlier than the cycle after acceptance. There is no same-cycle bypass.
- Simultaneous push and pop: both occur, and fifo_level is unchanged.
- While FIFO is full and reads are continuous: host_wr_ready stays 0 indefinitely. Display is never stalled.
- Hazard: a read of an address with a pending FIFO write returns old RAM data. This is allowed, because reads and writes target different banks when ping-pong is enabled.
- Swap, with the ping-pong feature:
  - swap_req sets swap_pending.
  - On a vs rising edge with swap_pending=1 and FIFO empty: bank_sel toggles, swap_pending clears, and swap_done pulses 1 cycle later, coincident with the new bank_sel.
  - If the FIFO is non-empty at the edge, the swap is deferred to the next vs rising edge.
  - swap_req arriving in the same cycle as a qualifying edge takes effect at that edge.
- rst mid-operation: FIFO contents lost, pending swap lost, bank_sel returns to 0, and a read in flight produces no vld.

Optional Feature:
- Macro FB_PINGPONG_EN.
- Defined: behaviour as above, with two banks. ram_addr MSB selects the bank: reads use the front bank, writes use the back bank.
- Undefined: single bank. ram_addr MSB is always 0. swap_req is ignored. bank_sel and swap_done are tied 0. Writes go to the same bank that is displayed.

Test Plan:
- Reset then idle: after rst deasserts, ram_en=0, host_wr_ready=1, fifo_level=0, drop_cnt=0.
- Single host write: addr 5, data 8'hA3, no reads → ram_we=1 at addr {~0,5} the next cycle. A subsequent read of addr 5 after a swap returns 8'hA3 with vld 1 cycle after the request.
- Read priority: 6 host writes pushed during 20 continuous read cycles → 4 accepted, then host_wr_ready=0. No writes issue during the reads. All 4 retire in the 4 cycles after the reads stop.
- Out-of-range: host write to addr 784 and addr 1023 → both accepted, FIFO unchanged, drop_cnt=2. After 300 such writes, drop_cnt=255.
- Swap deferral (FB_PINGPONG_EN): swap_req issued, FIFO holding 2 entries and continuous reads across a vs edge → no swap at that edge. At the next vs edge with FIFO empty → bank_sel 0→1 and a single swap_done pulse.
- Reset mid-burst: rst asserted with fifo_level=3 and a read outstanding → no vld after reset, fifo_level=0, no RAM write issued.
